// File: rtl/prio_arb8_ctrl.sv
// prio_arb8_ctrl
//
// Sequential arbiter sharing one resource among eight requesters. A request
// vector sampled in IDLE picks one owner, by fixed priority (highest index
// wins) or round-robin (first requester after the previous owner). The
// grant is registered and held until the owner drops its request or the
// optional hold limit expires. A requester that was forcibly revoked is
// masked for the next arbitration, unless it is the only requester.
//
// Handshake: requester i raises req[i] and keeps it high for as long as it
// wants the resource. The grant appears one cycle after req is sampled in
// IDLE. A grant never moves to another requester while it is held. The
// owner ends the grant by dropping req[i]. Every grant is followed by at
// least one cycle with gnt=0.
//
// Parameters
//   RR_MODE   0 = fixed priority (req[7] highest), 1 = round-robin
//   MAX_HOLD  maximum consecutive grant cycles (1..255), 0 = no limit
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req[7:0]   request vector
//   gnt[7:0]   registered one-hot grant, zero when there is no owner
//   gnt_id     binary index of the owner, meaningful while gnt_valid=1
//   gnt_valid  a grant is active (|gnt)
//   idle       controller is in IDLE
//   timeout    one-cycle pulse in the cycle after a forced revoke

module prio_arb8_ctrl #(
    parameter bit RR_MODE  = 1'b0,
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       idle,
    output logic       timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam bit         HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [7:0] HOLD_LAST = HOLD_EN ? 8'(MAX_HOLD - 1) : 8'd0;

    state_t     state, state_next;
    logic [7:0] gnt_next;
    logic [2:0] gnt_id_next;
    logic       timeout_next;
    logic [2:0] last_id, last_id_next;
    logic [7:0] hold_cnt, hold_next;
    logic       mask_valid, mask_valid_next;
    logic [2:0] mask_id, mask_id_next;

    logic [7:0] eff_masked;
    logic [7:0] eff_req;
    logic [2:0] win_id;
    logic [2:0] scan_idx;
    logic       owner_release;
    logic       hold_hit;

    // Drop the masked requester, but fall back to the raw vector so a lone
    // masked requester can still be served.
    always_comb begin
        eff_masked = req;
        if (mask_valid) begin
            eff_masked[mask_id] = 1'b0;
        end
        eff_req = (eff_masked == 8'd0) ? req : eff_masked;
    end

    // Winner select. Later loop iterations override earlier ones, so the
    // loop order encodes the priority: ascending index for fixed priority
    // (highest wins), descending scan distance for round-robin (nearest
    // index after last_id wins).
    always_comb begin
        win_id   = 3'd0;
        scan_idx = 3'd0;
        if (RR_MODE) begin
            for (int k = 7; k >= 0; k--) begin
                scan_idx = last_id + 3'd1 + 3'(k);
                if (eff_req[scan_idx]) begin
                    win_id = scan_idx;
                end
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (eff_req[i]) begin
                    win_id = 3'(i);
                end
            end
        end
    end

    assign owner_release = ~req[gnt_id];
    assign hold_hit      = HOLD_EN && (hold_cnt == HOLD_LAST);

    always_comb begin
        state_next      = state;
        gnt_next        = gnt;
        gnt_id_next     = gnt_id;
        timeout_next    = 1'b0;
        last_id_next    = last_id;
        hold_next       = hold_cnt;
        mask_valid_next = mask_valid;
        mask_id_next    = mask_id;
        case (state)
            IDLE: begin
                if (req != 8'd0) begin
                    gnt_next        = 8'd1 << win_id;
                    gnt_id_next     = win_id;
                    hold_next       = 8'd0;
                    mask_valid_next = 1'b0;
                    state_next      = BUSY;
                end
            end
            BUSY: begin
                if (owner_release || hold_hit) begin
                    gnt_next     = 8'd0;
                    last_id_next = gnt_id;
                    state_next   = IDLE;
                    // A release in the same cycle as the limit is a normal
                    // hand-back: no pulse and no mask.
                    if (!owner_release) begin
                        mask_valid_next = 1'b1;
                        mask_id_next    = gnt_id;
                        timeout_next    = 1'b1;
                    end
                end else begin
                    hold_next = hold_cnt + 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            gnt        <= 8'd0;
            gnt_id     <= 3'd0;
            timeout    <= 1'b0;
            last_id    <= 3'd7;
            hold_cnt   <= 8'd0;
            mask_valid <= 1'b0;
            mask_id    <= 3'd0;
        end else begin
            state      <= state_next;
            gnt        <= gnt_next;
            gnt_id     <= gnt_id_next;
            timeout    <= timeout_next;
            last_id    <= last_id_next;
            hold_cnt   <= hold_next;
            mask_valid <= mask_valid_next;
            mask_id    <= mask_id_next;
        end
    end

    assign gnt_valid = |gnt;
    assign idle      = (state == IDLE);

endmodule

// File: tb/tb_prio_arb8_ctrl.sv
// Directed bench for prio_arb8_ctrl. Four instances with different
// parameter sets share one clock and reset, each with its own request.
//   u_fix : fixed priority, no hold limit
//   u_rr  : round-robin, MAX_HOLD=2
//   u_tm  : fixed priority, MAX_HOLD=4
//   u_col : fixed priority, MAX_HOLD=3

module tb_prio_arb8_ctrl;

    logic clk;
    logic rst_n;

    logic [7:0] req_f, req_r, req_t, req_c;
    logic [7:0] gnt_f, gnt_r, gnt_t, gnt_c;
    logic [2:0] id_f, id_r, id_t, id_c;
    logic       gv_f, gv_r, gv_t, gv_c;
    logic       idle_f, idle_r, idle_t, idle_c;
    logic       to_f, to_r, to_t, to_c;

    int total;
    int bad;

    prio_arb8_ctrl #(.RR_MODE(1'b0), .MAX_HOLD(0)) u_fix (
        .clk(clk), .rst_n(rst_n), .req(req_f), .gnt(gnt_f), .gnt_id(id_f),
        .gnt_valid(gv_f), .idle(idle_f), .timeout(to_f)
    );

    prio_arb8_ctrl #(.RR_MODE(1'b1), .MAX_HOLD(2)) u_rr (
        .clk(clk), .rst_n(rst_n), .req(req_r), .gnt(gnt_r), .gnt_id(id_r),
        .gnt_valid(gv_r), .idle(idle_r), .timeout(to_r)
    );

    prio_arb8_ctrl #(.RR_MODE(1'b0), .MAX_HOLD(4)) u_tm (
        .clk(clk), .rst_n(rst_n), .req(req_t), .gnt(gnt_t), .gnt_id(id_t),
        .gnt_valid(gv_t), .idle(idle_t), .timeout(to_t)
    );

    prio_arb8_ctrl #(.RR_MODE(1'b0), .MAX_HOLD(3)) u_col (
        .clk(clk), .rst_n(rst_n), .req(req_c), .gnt(gnt_c), .gnt_id(id_c),
        .gnt_valid(gv_c), .idle(idle_c), .timeout(to_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Grant state of one instance: one-hot gnt, index, valid, idle, timeout.
    task automatic check_owner(input string tag, input logic [7:0] g, input logic [2:0] id,
                               input logic gv, input logic idl, input logic to,
                               input logic [2:0] exp_id);
        check({tag, "_gnt"}, g, 8'd1 << exp_id);
        check({tag, "_id"}, {5'd0, id}, {5'd0, exp_id});
        check({tag, "_gv_idle_to"}, {5'd0, gv, idl, to}, 8'b0000_0100);
    endtask

    // Gap cycle after a grant: nothing granted, idle, timeout as expected.
    task automatic check_gap(input string tag, input logic [7:0] g, input logic gv,
                             input logic idl, input logic to, input logic exp_to);
        check({tag, "_gnt"}, g, 8'd0);
        check({tag, "_gv_idle_to"}, {5'd0, gv, idl, to}, {5'd0, 1'b0, 1'b1, exp_to});
    endtask

    initial begin
        logic [2:0] rr_seq [4];
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        req_f = 8'd0;
        req_r = 8'd0;
        req_t = 8'd0;
        req_c = 8'd0;
        rr_seq[0] = 3'd2;
        rr_seq[1] = 3'd3;
        rr_seq[2] = 3'd7;
        rr_seq[3] = 3'd2;

        // Reset values.
        #12;
        check("rst_gnt", gnt_f, 8'd0);
        check("rst_id", {5'd0, id_f}, 8'd0);
        check("rst_gv_idle_to", {5'd0, gv_f, idle_f, to_f}, 8'b0000_0010);
        #10;
        rst_n = 1'b1;
        step();

        // Fixed priority: 00100010 for three edges -> id 5 for three cycles.
        req_f = 8'b0010_0010;
        for (int i = 0; i < 3; i++) begin
            step();
            check_owner("fix_hold", gnt_f, id_f, gv_f, idle_f, to_f, 3'd5);
        end
        req_f = 8'd0;
        step();
        check_gap("fix_release", gnt_f, gv_f, idle_f, to_f, 1'b0);

        // No preemption: id 0 keeps the grant while req[7] waits.
        req_f = 8'b0000_0001;
        step();
        check_owner("nopre_first", gnt_f, id_f, gv_f, idle_f, to_f, 3'd0);
        req_f = 8'b1000_0001;
        step();
        check_owner("nopre_held1", gnt_f, id_f, gv_f, idle_f, to_f, 3'd0);
        step();
        check_owner("nopre_held2", gnt_f, id_f, gv_f, idle_f, to_f, 3'd0);
        req_f = 8'b1000_0000;
        step();
        check_gap("nopre_gap", gnt_f, gv_f, idle_f, to_f, 1'b0);
        step();
        check_owner("nopre_next", gnt_f, id_f, gv_f, idle_f, to_f, 3'd7);
        req_f = 8'd0;
        step();
        check_gap("nopre_end", gnt_f, gv_f, idle_f, to_f, 1'b0);

        // MAX_HOLD=0: a grant held for 40 cycles is never revoked.
        req_f = 8'b0000_0100;
        step();
        for (int i = 0; i < 40; i++) begin
            step();
        end
        check_owner("nolimit_held", gnt_f, id_f, gv_f, idle_f, to_f, 3'd2);
        req_f = 8'd0;
        step();
        check_gap("nolimit_end", gnt_f, gv_f, idle_f, to_f, 1'b0);

        // Round-robin, MAX_HOLD=2: owners rotate 2, 3, 7, 2.
        req_r = 8'b1000_1100;
        for (int n = 0; n < 4; n++) begin
            step();
            check_owner("rr_c1", gnt_r, id_r, gv_r, idle_r, to_r, rr_seq[n]);
            step();
            check_owner("rr_c2", gnt_r, id_r, gv_r, idle_r, to_r, rr_seq[n]);
            step();
            check_gap("rr_gap", gnt_r, gv_r, idle_r, to_r, 1'b1);
        end
        req_r = 8'd0;
        step();
        check_gap("rr_end", gnt_r, gv_r, idle_r, to_r, 1'b0);

        // Timeout masking, MAX_HOLD=4: 6, 0, 6 with a timeout gap after each.
        req_t = 8'b0100_0001;
        for (int n = 0; n < 3; n++) begin
            for (int c = 0; c < 4; c++) begin
                step();
                check_owner("tm_own", gnt_t, id_t, gv_t, idle_t, to_t, (n == 1) ? 3'd0 : 3'd6);
            end
            step();
            check_gap("tm_gap", gnt_t, gv_t, idle_t, to_t, 1'b1);
        end
        // Lone masked requester still wins, twice in a row.
        req_t = 8'b0100_0000;
        for (int n = 0; n < 2; n++) begin
            for (int c = 0; c < 4; c++) begin
                step();
                check_owner("tm_lone", gnt_t, id_t, gv_t, idle_t, to_t, 3'd6);
            end
            step();
            check_gap("tm_lone_gap", gnt_t, gv_t, idle_t, to_t, 1'b1);
        end
        req_t = 8'd0;
        step();
        check_gap("tm_end", gnt_t, gv_t, idle_t, to_t, 1'b0);

        // Release/timeout collision, MAX_HOLD=3: owner 1 drops in cycle 3.
        req_c = 8'b0000_0011;
        for (int c = 0; c < 3; c++) begin
            step();
            check_owner("col_own", gnt_c, id_c, gv_c, idle_c, to_c, 3'd1);
        end
        req_c = 8'b0000_0001;
        step();
        check_gap("col_gap", gnt_c, gv_c, idle_c, to_c, 1'b0);
        // No mask on id 1, so it wins again over id 0.
        req_c = 8'b0000_0011;
        step();
        check_owner("col_nomask", gnt_c, id_c, gv_c, idle_c, to_c, 3'd1);
        req_c = 8'd0;
        step();
        check_gap("col_end", gnt_c, gv_c, idle_c, to_c, 1'b0);

        // Async reset mid-grant on the round-robin instance (last owner 2 -> id 3).
        req_r = 8'b1111_1111;
        step();
        check_owner("ar_pre", gnt_r, id_r, gv_r, idle_r, to_r, 3'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check_gap("ar_during", gnt_r, gv_r, idle_r, to_r, 1'b0);
        check("ar_id", {5'd0, id_r}, 8'd0);
        #3;
        rst_n = 1'b1;
        step();
        check_owner("ar_first_rr", gnt_r, id_r, gv_r, idle_r, to_r, 3'd0);
        step();
        check_owner("ar_second", gnt_r, id_r, gv_r, idle_r, to_r, 3'd0);
        step();
        check_gap("ar_gap", gnt_r, gv_r, idle_r, to_r, 1'b1);
        step();
        check_owner("ar_rot", gnt_r, id_r, gv_r, idle_r, to_r, 3'd1);
        req_r = 8'd0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
